alu_muldiv_ctrl: RTL
====================

# alu_muldiv_ctrl

Parametrised ALU control for the MIPS execute stage. Decodes `AluOp`/`Func` into an extended 4-bit `AluCtrl` covering the full R-type integer set. It also owns an iterative multiply/divide engine with HI/LO registers, and holds the pipeline via `Stall` while that engine is busy. It sits between the main control unit and the ALU, in parallel with the ALU datapath.

## Interface
- `WIDTH`, 32: operand/HI/LO width; even, ≥4.
- `Clk`  in  1  clock; all state updates on rising edge.
- `RstN`  in  1  reset; synchronous, active-low.
- `Valid`  in  1  instruction in execute stage is real (not a bubble).
- `AluOp`  in  2  from main control: 00 add, 01 sub, 10 R-type (use `Func`), 11 or (ori).
- `Func`  in  6  instruction funct field.
- `A`, `B`  in  WIDTH  rs / rt operand values.
- `AluCtrl`  out  4  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0011 xor, 1100 nor, 0111 slt, 1111 sltu, 1000 sll, 1001 srl, 1010 sra.
- `Illegal`  out  1  `Valid` and no decode match.
- `MdSel`  out  1  result mux selects `MdResult` instead of the ALU (mfhi/mflo).
- `MdResult`  out  WIDTH  HI for mfhi, LO otherwise.
- `Stall`  out  1  hold the execute stage this cycle.
- `Busy`  out  1  engine running.

## Operation
- Decode is combinational.
  - AluOp 00/01/11 ignore `Func`.
  - AluOp 10 funct map:
    - 10000x→add, 10001x→sub, 100100→and, 100101→or, 100110→xor, 100111→nor.
    - 101010→slt, 101011→sltu, 000000→sll, 000010→srl, 000011→sra.
    - 010000 mfhi, 010010 mflo, 011000 mult, 011001 multu, 011010 div, 011011 divu.
  - Unmatched with `Valid`=1: `AluCtrl`=0010, `Illegal`=1. Never X.
- Md ops: mult, multu, div, divu (start), mfhi, mflo (read).
- `Stall` = `Valid` & md op & `Busy`. A held op re-presents the same `Func`/`A`/`B` until `Stall` drops.
- Start accepted when `Valid` & start op & ~`Busy`; operands are latched on that edge.
- FSM states: IDLE → RUN (WIDTH cycles) → FIX (1 cycle) → IDLE.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle, on magnitudes.
  - FIX: applies sign to the results and writes HI/LO.
- Signed operations:
  - mult: {HI,LO} = signed 2W product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Unsigned forms treat operands as unsigned.
- Divide by zero: LO = all ones, HI = A; full latency.
- Signed MIN / −1: LO = MIN, HI = 0.
- mfhi/mflo with ~`Busy`: `MdSel`=1, `MdResult` = HI/LO; no stall.

## Timing
- Reset (`RstN`=0 at edge): state IDLE, `Busy`=0, HI=LO=0, operand registers 0. `MdResult` therefore reads 0.
- Reset mid-operation abandons the op; HI/LO return to 0 at that edge.
- Start accepted at edge t: `Busy`=1 from t through t+WIDTH+1. HI/LO are written at edge t+WIDTH+1, where `Busy` falls.
- Total latency is WIDTH+1 cycles (33 for WIDTH=32).
- A start issued in the cycle `Busy` falls is accepted; back-to-back ops add no gap cycle.
- Non-md instructions never stall while `Busy`. HI/LO are architecturally stale until FIX.
- mfhi on the cycle after `Busy` falls returns the new value.

## Configuration
- `ALU_MULDIV_EN` defined: engine, HI/LO, and the md decodes are present as above.
- Not defined:
  - Md functs decode as illegal (`Illegal`=1 with `Valid`).
  - `Busy`, `Stall`, `MdSel` tied 0; `MdResult` tied 0.
  - No registers are inferred.

## Structure
- Package `alu_pkg`:
  - `AluCtrl` encodings as named constants.
  - Funct codes.
  - md op enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
  - FSM state enum (IDLE, RUN, FIX).
- Sub-module `muldiv_core`: iterative engine, FSM, step counter, HI/LO. Interface: start, op, A, B → busy, hi, lo.
- Decoder and stall logic live in the top.

## Test plan
- Decode sweep: AluOp=10, each listed funct → listed `AluCtrl`. Func=111111 with `Valid`=1 → `AluCtrl`=0010, `Illegal`=1. AluOp=11 → 0001.
- mult, A=−3, B=7, WIDTH=32 → `Busy` for exactly 33 cycles; then mflo=FFFFFFEB, mfhi=FFFFFFFF.
- div, A=−7, B=2 → LO=FFFFFFFD, HI=FFFFFFFF. divu, A=7, B=0 → LO=FFFFFFFF, HI=00000007.
- mflo issued 5 cycles after mult start → `Stall`=1 until `Busy` falls, then `MdResult`=new LO. An add issued while `Busy` → `Stall`=0.
- `RstN`=0 at cycle 10 of a div → next cycle `Busy`=0, HI=LO=0; a subsequent multu 0xFFFFFFFF×2 → HI=1, LO=FFFFFFFE.
- Build without `ALU_MULDIV_EN`: mult funct → `Illegal`=1, `Stall`=0, `Busy`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the MIPS execute-stage ALU control and multiply/divide engine.
// The engine and its decodes exist only when ALU_MULDIV_EN is defined.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  // Bit 1 set means divide, bit 0 set means unsigned.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative multiply/divide engine: WIDTH magnitude steps in RUN, sign fix-up and
// HI/LO write in FIX. The FSM state is exported on o_state for observation.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [1:0]       o_state
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          r_state;
  md_state_e          w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_m;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_bz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_a[WIDTH-1];
  assign w_b_neg  = w_signed & i_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;

  // r_p holds {partial product, multiplier} or {remainder, dividend/quotient}.
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};
  assign w_rem_sh   = r_p[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_m};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_p[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_q ? -r_p : r_p;
  assign w_quo  = r_neg_q ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (r_cnt == CW'(WIDTH-1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_p     <= {{WIDTH{1'b0}}, w_a_mag};
            r_m     <= w_b_mag;
            r_div   <= i_op[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_bz    <= (i_b == '0);
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_p   <= r_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          if (r_div) begin
            // A zero divisor leaves the dividend magnitude as remainder, so HI = A falls out.
            r_lo <= r_bz ? '1 : w_quo;
            r_hi <= w_rem;
          end else begin
            r_lo <= w_prod[WIDTH-1:0];
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (r_state != IDLE);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_state = r_state;

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// MIPS execute-stage ALU control: AluOp/Func decode plus stall logic around the
// multiply/divide engine, which is built only when ALU_MULDIV_EN is defined.
module alu_muldiv_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Valid,
  input  logic [1:0]       AluOp,
  input  logic [5:0]       Func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [3:0]       AluCtrl,
  output logic             Illegal,
  output logic             MdSel,
  output logic [WIDTH-1:0] MdResult,
  output logic             Stall,
  output logic             Busy
);

  logic w_match;
`ifdef ALU_MULDIV_EN
  logic             w_mfhi;
  logic             w_mflo;
  logic             w_start;
  logic [1:0]       w_md_op;
  logic             w_busy;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [1:0]       w_state;
`endif

  always_comb begin
    AluCtrl = ALU_ADD;
    w_match = 1'b0;
`ifdef ALU_MULDIV_EN
    w_mfhi  = 1'b0;
    w_mflo  = 1'b0;
    w_start = 1'b0;
    w_md_op = MD_MULT;
`endif
    case (AluOp)
      ALUOP_ADD: begin AluCtrl = ALU_ADD; w_match = 1'b1; end
      ALUOP_SUB: begin AluCtrl = ALU_SUB; w_match = 1'b1; end
      ALUOP_ORI: begin AluCtrl = ALU_OR;  w_match = 1'b1; end
      default: begin
        casez (Func)
          6'b10000?: begin AluCtrl = ALU_ADD;  w_match = 1'b1; end
          6'b10001?: begin AluCtrl = ALU_SUB;  w_match = 1'b1; end
          F_AND:     begin AluCtrl = ALU_AND;  w_match = 1'b1; end
          F_OR:      begin AluCtrl = ALU_OR;   w_match = 1'b1; end
          F_XOR:     begin AluCtrl = ALU_XOR;  w_match = 1'b1; end
          F_NOR:     begin AluCtrl = ALU_NOR;  w_match = 1'b1; end
          F_SLT:     begin AluCtrl = ALU_SLT;  w_match = 1'b1; end
          F_SLTU:    begin AluCtrl = ALU_SLTU; w_match = 1'b1; end
          F_SLL:     begin AluCtrl = ALU_SLL;  w_match = 1'b1; end
          F_SRL:     begin AluCtrl = ALU_SRL;  w_match = 1'b1; end
          F_SRA:     begin AluCtrl = ALU_SRA;  w_match = 1'b1; end
`ifdef ALU_MULDIV_EN
          F_MFHI:    begin w_mfhi = 1'b1; w_match = 1'b1; end
          F_MFLO:    begin w_mflo = 1'b1; w_match = 1'b1; end
          F_MULT:    begin w_start = 1'b1; w_md_op = MD_MULT;  w_match = 1'b1; end
          F_MULTU:   begin w_start = 1'b1; w_md_op = MD_MULTU; w_match = 1'b1; end
          F_DIV:     begin w_start = 1'b1; w_md_op = MD_DIV;   w_match = 1'b1; end
          F_DIVU:    begin w_start = 1'b1; w_md_op = MD_DIVU;  w_match = 1'b1; end
`endif
          default:   ;
        endcase
      end
    endcase
  end

  assign Illegal = Valid & ~w_match;

`ifdef ALU_MULDIV_EN
  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .i_clk   (Clk),
    .i_rst_n (RstN),
    .i_start (Valid & w_start & ~w_busy),
    .i_op    (w_md_op),
    .i_a     (A),
    .i_b     (B),
    .o_busy  (w_busy),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_state (w_state)
  );

  // Any md instruction waits out a running op; the held op keeps its operands.
  assign Stall    = Valid & (w_start | w_mfhi | w_mflo) & w_busy;
  assign MdSel    = Valid & (w_mfhi | w_mflo) & ~w_busy;
  assign MdResult = w_mfhi ? w_hi : w_lo;
  assign Busy     = w_busy;
`else
  logic w_unused;
  assign w_unused = ^{Clk, RstN, A, B};
  assign Stall    = 1'b0;
  assign MdSel    = 1'b0;
  assign MdResult = '0;
  assign Busy     = 1'b0;
`endif

endmodule
